// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage with a variable-latency req/ack RAM port.
// Handles lane placement, load extension, misalignment and wait timeout.
module mem_access_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  input  logic                in_RegWrite,
  input  logic                in_MemToReg,
  input  logic                in_RegDataSrc,
  input  logic                in_PCSrc,
  input  logic [REG_W-1:0]    in_RegDest,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                out_valid,
  output logic [DATA_W-1:0]   data_out,
  output logic                out_RegWrite,
  output logic                out_MemToReg,
  output logic                out_RegDataSrc,
  output logic                out_PCSrc,
  output logic [REG_W-1:0]    out_RegDest,
  output logic                stall,
  output logic                err_misaligned,
  output logic                err_timeout,
  output logic                err_illegal
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [STRB_W-1:0] r_mem_wstrb;
  logic [OFF_W-1:0]  r_off;
  logic [1:0]        r_size;
  logic              r_uns, r_load, r_tout;
  logic [DATA_W-1:0] r_result;
  logic              r_rw, r_m2r, r_rds, r_pcs;
  logic [REG_W-1:0]  r_rd;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_data_out;
  logic              r_out_rw, r_out_m2r, r_out_rds, r_out_pcs;
  logic [REG_W-1:0]  r_out_rd;
  logic              r_err_mis, r_err_to, r_err_ill;

  logic              w_accept, w_is_mem, w_ill, w_mis, w_go, w_tout;
  logic [OFF_W-1:0]  w_off;
  logic [STRB_W-1:0] w_mask;
  logic [DATA_W-1:0] w_shr, w_lsh, w_ext;
  logic signed [DATA_W-1:0] w_sext;
  logic [6:0]        w_sh;

  assign w_off    = addr[OFF_W-1:0];
  assign w_accept = in_valid && (r_state == IDLE);
  assign w_is_mem = MemRead || MemWrite;
  assign w_ill    = (MemRead && MemWrite) ||
                    (w_is_mem && size == 2'b11 && DATA_W == 32);

  always_comb begin
    w_mis = 1'b0;
    case (size)
      2'b01:   w_mis = addr[0];
      2'b10:   w_mis = |addr[1:0];
      2'b11:   w_mis = |addr[2:0];
      default: w_mis = 1'b0;
    endcase
    w_mis = w_mis && w_is_mem && !w_ill;
  end

  assign w_go   = w_accept && w_is_mem && !w_ill && !w_mis;
  assign w_tout = (r_state == WAIT) && !mem_ack &&
                  (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_mask = '0;
    case (size)
      2'b00:   w_mask = STRB_W'(8'h01);
      2'b01:   w_mask = STRB_W'(8'h03);
      2'b10:   w_mask = STRB_W'(8'h0F);
      default: w_mask = STRB_W'(8'hFF);
    endcase
  end

  // Extension: push the field to the top, then shift back down.
  always_comb begin
    w_sh = 7'd0;
    case (r_size)
      2'b00:   w_sh = 7'(DATA_W - 8);
      2'b01:   w_sh = 7'(DATA_W - 16);
      2'b10:   w_sh = 7'(DATA_W - 32);
      default: w_sh = 7'd0;
    endcase
  end

  assign w_shr  = mem_rdata >> {r_off, 3'b000};
  assign w_lsh  = w_shr << w_sh;
  assign w_sext = $signed(w_lsh) >>> w_sh;
  assign w_ext  = r_uns ? (w_lsh >> w_sh) : w_sext;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_go) w_state_nxt = WAIT;
      WAIT: if (mem_ack || w_tout) w_state_nxt = RESP;
      RESP: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_off       <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_load      <= 1'b0;
      r_tout      <= 1'b0;
      r_result    <= '0;
      r_rw        <= 1'b0;
      r_m2r       <= 1'b0;
      r_rds       <= 1'b0;
      r_pcs       <= 1'b0;
      r_rd        <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_out_rw    <= 1'b0;
      r_out_m2r   <= 1'b0;
      r_out_rds   <= 1'b0;
      r_out_pcs   <= 1'b0;
      r_out_rd    <= '0;
      r_err_mis   <= 1'b0;
      r_err_to    <= 1'b0;
      r_err_ill   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_err_mis   <= 1'b0;
      r_err_to    <= 1'b0;
      r_err_ill   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_go) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= MemWrite;
            r_mem_addr  <= {addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            r_mem_wdata <= data_in << {w_off, 3'b000};
            r_mem_wstrb <= MemWrite ? (w_mask << w_off) : '0;
            r_off       <= w_off;
            r_size      <= size;
            r_uns       <= is_unsigned;
            r_load      <= MemRead;
            r_tout      <= 1'b0;
            r_cnt       <= '0;
            r_rw        <= in_RegWrite;
            r_m2r       <= in_MemToReg;
            r_rds       <= in_RegDataSrc;
            r_pcs       <= in_PCSrc;
            r_rd        <= in_RegDest;
          end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_data_out  <= w_is_mem ? '0 : DATA_W'(addr);
            r_out_rw    <= in_RegWrite && !w_ill && !w_mis;
            r_out_m2r   <= in_MemToReg;
            r_out_rds   <= in_RegDataSrc;
            r_out_pcs   <= in_PCSrc;
            r_out_rd    <= in_RegDest;
            r_err_ill   <= w_ill;
            r_err_mis   <= w_mis;
          end
        end
        WAIT: begin
          if (mem_ack || w_tout) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= '0;
            r_tout      <= !mem_ack;
            r_result    <= (mem_ack && r_load) ? w_ext : '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_out_valid <= 1'b1;
          r_data_out  <= r_result;
          r_out_rw    <= r_rw && !r_tout;
          r_out_m2r   <= r_m2r;
          r_out_rds   <= r_rds;
          r_out_pcs   <= r_pcs;
          r_out_rd    <= r_rd;
          r_err_to    <= r_tout;
        end
        default: ;
      endcase
    end
  end

  assign in_ready       = (r_state == IDLE);
  assign stall          = !in_ready;
  assign mem_req        = r_mem_req;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign mem_wstrb      = r_mem_wstrb;
  assign out_valid      = r_out_valid;
  assign data_out       = r_data_out;
  assign out_RegWrite   = r_out_rw;
  assign out_MemToReg   = r_out_m2r;
  assign out_RegDataSrc = r_out_rds;
  assign out_PCSrc      = r_out_pcs;
  assign out_RegDest    = r_out_rd;
  assign err_misaligned = r_err_mis;
  assign err_timeout    = r_err_to;
  assign err_illegal    = r_err_ill;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a 32-bit build with a short
// timeout and a 64-bit build, checked against hand-computed vectors.
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic        a_iv, a_ir, a_rd, a_wr, a_uns;
  logic        a_rw, a_m2r, a_rds, a_pcs;
  logic [31:0] a_addr, a_din, a_maddr, a_wdata, a_rdata, a_dout;
  logic [1:0]  a_size;
  logic [4:0]  a_rdst, a_ordst;
  logic        a_req, a_we, a_ack, a_ov;
  logic [3:0]  a_wstrb;
  logic        a_orw, a_om2r, a_ords, a_opcs;
  logic        a_stall, a_emis, a_eto, a_eill;

  logic        b_iv, b_ir, b_rd, b_wr, b_uns;
  logic        b_rw, b_m2r, b_rds, b_pcs;
  logic [31:0] b_addr, b_maddr;
  logic [63:0] b_din, b_wdata, b_rdata, b_dout;
  logic [1:0]  b_size;
  logic [4:0]  b_rdst, b_ordst;
  logic        b_req, b_we, b_ack, b_ov;
  logic [7:0]  b_wstrb;
  logic        b_orw, b_om2r, b_ords, b_opcs;
  logic        b_stall, b_emis, b_eto, b_eill;

  mem_access_stage #(.DATA_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(a_iv), .in_ready(a_ir),
    .addr(a_addr), .data_in(a_din),
    .MemRead(a_rd), .MemWrite(a_wr),
    .size(a_size), .is_unsigned(a_uns),
    .in_RegWrite(a_rw), .in_MemToReg(a_m2r),
    .in_RegDataSrc(a_rds), .in_PCSrc(a_pcs),
    .in_RegDest(a_rdst),
    .mem_req(a_req), .mem_we(a_we),
    .mem_addr(a_maddr), .mem_wdata(a_wdata),
    .mem_wstrb(a_wstrb), .mem_ack(a_ack),
    .mem_rdata(a_rdata),
    .out_valid(a_ov), .data_out(a_dout),
    .out_RegWrite(a_orw), .out_MemToReg(a_om2r),
    .out_RegDataSrc(a_ords), .out_PCSrc(a_opcs),
    .out_RegDest(a_ordst), .stall(a_stall),
    .err_misaligned(a_emis), .err_timeout(a_eto),
    .err_illegal(a_eill)
  );

  mem_access_stage #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(b_iv), .in_ready(b_ir),
    .addr(b_addr), .data_in(b_din),
    .MemRead(b_rd), .MemWrite(b_wr),
    .size(b_size), .is_unsigned(b_uns),
    .in_RegWrite(b_rw), .in_MemToReg(b_m2r),
    .in_RegDataSrc(b_rds), .in_PCSrc(b_pcs),
    .in_RegDest(b_rdst),
    .mem_req(b_req), .mem_we(b_we),
    .mem_addr(b_maddr), .mem_wdata(b_wdata),
    .mem_wstrb(b_wstrb), .mem_ack(b_ack),
    .mem_rdata(b_rdata),
    .out_valid(b_ov), .data_out(b_dout),
    .out_RegWrite(b_orw), .out_MemToReg(b_om2r),
    .out_RegDataSrc(b_ords), .out_PCSrc(b_opcs),
    .out_RegDest(b_ordst), .stall(b_stall),
    .err_misaligned(b_emis), .err_timeout(b_eto),
    .err_illegal(b_eill)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load32(input string tag, input logic [31:0] a,
                        input logic [1:0] sz, input logic u,
                        input logic [31:0] rd, input int waits,
                        input logic [31:0] exp);
    a_addr = a; a_rd = 1'b1; a_wr = 1'b0;
    a_size = sz; a_uns = u; a_rw = 1'b1;
    a_m2r = 1'b1; a_rdst = 5'd9; a_iv = 1'b1;
    step();
    a_iv = 1'b0; a_rd = 1'b0; a_m2r = 1'b0;
    chk({tag, "_req"}, a_req, 1);
    chk({tag, "_maddr"}, a_maddr, {a[31:2], 2'b00});
    chk({tag, "_stall"}, a_stall, 1);
    for (int i = 0; i < waits; i++) begin
      step();
      chk({tag, "_wreq"}, a_req, 1);
      chk({tag, "_wstall"}, a_stall, 1);
    end
    a_ack = 1'b1; a_rdata = rd;
    step();
    a_ack = 1'b0; a_rdata = '0;
    chk({tag, "_reqdrop"}, a_req, 0);
    chk({tag, "_ov0"}, a_ov, 0);
    step();
    chk({tag, "_ov"}, a_ov, 1);
    chk({tag, "_dout"}, a_dout, exp);
    chk({tag, "_orw"}, a_orw, 1);
    chk({tag, "_om2r"}, a_om2r, 1);
    chk({tag, "_ordst"}, a_ordst, 9);
    chk({tag, "_ready"}, a_ir, 1);
    step();
    chk({tag, "_ovlow"}, a_ov, 0);
  endtask

  task automatic load64(input string tag, input logic [31:0] a,
                        input logic [1:0] sz, input logic u,
                        input logic [63:0] rd,
                        input logic [63:0] exp);
    b_addr = a; b_rd = 1'b1; b_wr = 1'b0;
    b_size = sz; b_uns = u; b_rw = 1'b1; b_iv = 1'b1;
    step();
    b_iv = 1'b0; b_rd = 1'b0;
    chk({tag, "_req"}, b_req, 1);
    chk({tag, "_maddr"}, b_maddr, {a[31:3], 3'b000});
    b_ack = 1'b1; b_rdata = rd;
    step();
    b_ack = 1'b0; b_rdata = '0;
    step();
    chk({tag, "_ov"}, b_ov, 1);
    chk({tag, "_dout"}, b_dout, exp);
    step();
  endtask

  initial begin
    a_iv = 0; a_rd = 0; a_wr = 0; a_uns = 0;
    a_rw = 0; a_m2r = 0; a_rds = 0; a_pcs = 0;
    a_addr = 0; a_din = 0; a_size = 0; a_rdst = 0;
    a_ack = 0; a_rdata = 0;
    b_iv = 0; b_rd = 0; b_wr = 0; b_uns = 0;
    b_rw = 0; b_m2r = 0; b_rds = 0; b_pcs = 0;
    b_addr = 0; b_din = 0; b_size = 0; b_rdst = 0;
    b_ack = 0; b_rdata = 0;

    #1;
    chk("rst_req", a_req, 0);
    chk("rst_we", a_we, 0);
    chk("rst_wstrb", a_wstrb, 0);
    chk("rst_maddr", a_maddr, 0);
    chk("rst_ov", a_ov, 0);
    chk("rst_dout", a_dout, 0);
    chk("rst_ready", a_ir, 1);
    chk("rst_err", {a_emis, a_eto, a_eill}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();

    load32("lb_s", 32'h1003, 2'b00, 1'b0, 32'h80FF_FFFF, 2,
           32'hFFFF_FF80);
    load32("lbu", 32'h1001, 2'b00, 1'b1, 32'h0000_9A00, 0,
           32'h0000_009A);
    load32("lh_s", 32'h0002, 2'b01, 1'b0, 32'h8001_0000, 1,
           32'hFFFF_8001);
    load32("lhu", 32'h0006, 2'b01, 1'b1, 32'hF00D_1234, 0,
           32'h0000_F00D);
    load32("lw", 32'h0008, 2'b10, 1'b0, 32'hDEAD_BEEF, 0,
           32'hDEAD_BEEF);

    // store half, immediate ack
    a_addr = 32'h2002; a_din = 32'h0000_ABCD; a_wr = 1'b1;
    a_size = 2'b01; a_rw = 1'b0; a_iv = 1'b1;
    step();
    a_iv = 1'b0; a_wr = 1'b0;
    chk("sh_req", a_req, 1);
    chk("sh_we", a_we, 1);
    chk("sh_wdata", a_wdata, 32'hABCD_0000);
    chk("sh_wstrb", a_wstrb, 4'b1100);
    chk("sh_maddr", a_maddr, 32'h2000);
    a_ack = 1'b1;
    step();
    a_ack = 1'b0;
    chk("sh_ov0", a_ov, 0);
    step();
    chk("sh_ov", a_ov, 1);
    chk("sh_dout", a_dout, 0);
    chk("sh_err", {a_emis, a_eto, a_eill}, 0);
    step();

    // misaligned word load
    a_addr = 32'h3001; a_rd = 1'b1; a_size = 2'b10;
    a_rw = 1'b1; a_iv = 1'b1;
    step();
    a_iv = 1'b0; a_rd = 1'b0;
    chk("mis_req", a_req, 0);
    chk("mis_ov", a_ov, 1);
    chk("mis_err", a_emis, 1);
    chk("mis_orw", a_orw, 0);
    chk("mis_ready", a_ir, 1);
    step();
    chk("mis_ovlow", a_ov, 0);
    chk("mis_errlow", a_emis, 0);
    chk("mis_req2", a_req, 0);

    // timeout after 4 wait cycles
    a_addr = 32'h4000; a_rd = 1'b1; a_size = 2'b10;
    a_rw = 1'b1; a_iv = 1'b1;
    step();
    a_iv = 1'b0; a_rd = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("to_req4", a_req, 1);
    step();
    chk("to_reqdrop", a_req, 0);
    a_ack = 1'b1; a_rdata = 32'h1234_5678;
    step();
    a_ack = 1'b0; a_rdata = 0;
    chk("to_ov", a_ov, 1);
    chk("to_err", a_eto, 1);
    chk("to_orw", a_orw, 0);
    chk("to_dout", a_dout, 0);
    step();
    chk("to_ovlow", a_ov, 0);
    chk("to_errlow", a_eto, 0);
    chk("to_req", a_req, 0);

    // illegal: dword on 32-bit, then read+write
    a_addr = 32'h0010; a_rd = 1'b1; a_size = 2'b11;
    a_rw = 1'b1; a_iv = 1'b1;
    step();
    a_size = 2'b10; a_wr = 1'b1;
    chk("ill_req", a_req, 0);
    chk("ill_ov", a_ov, 1);
    chk("ill_err", a_eill, 1);
    chk("ill_orw", a_orw, 0);
    step();
    a_iv = 1'b0; a_rd = 1'b0; a_wr = 1'b0;
    chk("rw_err", a_eill, 1);
    chk("rw_req", a_req, 0);
    step();
    chk("ill_errlow", a_eill, 0);

    // reset in the middle of WAIT
    a_addr = 32'h5000; a_rd = 1'b1; a_size = 2'b10; a_iv = 1'b1;
    step();
    a_iv = 1'b0; a_rd = 1'b0;
    chk("mr_req", a_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("mr_reqlow", a_req, 0);
    chk("mr_ready", a_ir, 1);
    @(negedge clk);
    a_ack = 1'b1; a_rdata = 32'hFFFF_FFFF;
    rst = 1'b1;
    a_addr = 32'h1234_5678; a_rw = 1'b1; a_rdst = 5'd3;
    a_pcs = 1'b1; a_iv = 1'b1;
    step();
    a_ack = 1'b0; a_rdata = 0;
    chk("nm_ov", a_ov, 1);
    chk("nm_dout", a_dout, 32'h1234_5678);
    chk("nm_ordst", a_ordst, 3);
    chk("nm_opcs", a_opcs, 1);
    chk("nm_req", a_req, 0);
    a_addr = 32'hCAFE_0000; a_pcs = 1'b0;
    step();
    a_iv = 1'b0;
    chk("nm2_ov", a_ov, 1);
    chk("nm2_dout", a_dout, 32'hCAFE_0000);
    chk("nm2_opcs", a_opcs, 0);
    step();
    chk("nm_ovlow", a_ov, 0);

    // 64-bit build
    load64("ld64", 32'h0008, 2'b11, 1'b0,
           64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
    load64("lb64", 32'h0015, 2'b00, 1'b0,
           64'h0000_AB00_0000_0000, 64'hFFFF_FFFF_FFFF_FFAB);
    b_addr = 32'h000C; b_rd = 1'b1; b_size = 2'b11; b_iv = 1'b1;
    step();
    b_iv = 1'b0; b_rd = 1'b0;
    chk("mis64_req", b_req, 0);
    chk("mis64_err", b_emis, 1);
    chk("mis64_ill", b_eill, 0);
    b_addr = 32'h0014; b_din = 64'h0000_0000_1122_3344;
    b_wr = 1'b1; b_size = 2'b10; b_iv = 1'b1;
    step();
    b_iv = 1'b0; b_wr = 1'b0;
    chk("sw64_wdata", b_wdata, 64'h1122_3344_0000_0000);
    chk("sw64_wstrb", b_wstrb, 8'hF0);
    b_ack = 1'b1;
    step();
    b_ack = 1'b0;
    step();
    chk("sw64_ov", b_ov, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
